game_core: RTL and testbench
============================

Name: game_core

Overview:
Sokoban game-state engine on an 8x8 board. Cells are indexed 0..63 as row*8+col, written in octal as o<row><col>. The block holds the current stage (level), the man position and the box positions. It applies mouse-driven moves, pushes, a one-step undo, level retry and stage advance. It exports per-cell bitmaps for the renderer and a win flag. It sits between the mouse/input decoder (cursor, buttons) and the VGA drawing logic.

Parameters:
NUM_STAGES, 4, number of levels in the level ROM; stage counter wraps modulo this value.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cursor  in  6  board cell under the mouse pointer (row*8+col)
game_area  in  1  1 = pointer is inside the board region
left  in  1  left mouse button level
right  in  1  right mouse button level
retract  in  1  undo request level
retry  in  1  restart-level request level
wall  out  64  bit i = cell i is wall (from level ROM)
way  out  64  bit i = cell i is floor (from level ROM)
box  out  64  bit i = box on cell i (state)
destination  out  64  bit i = cell i is a target (from level ROM)
man  out  6  man cell
stage  out  2  current level index
win  out  1  1 when box == destination

Behaviour:
- Clock, reset and state:
  - Single clock domain.
  - All state registers are updated on the posedge of clk.
  - Reset is asynchronous, active-high.
  - On reset: stage=0 and level 0 is loaded (man, box from ROM), undo_valid=0, and all edge-detect registers are cleared to 0.
- Level ROM outputs:
  - wall, way and destination are combinational ROM outputs indexed by stage.
  - win is combinational: (box == destination).
- Level 0 contents (hex, bit 0 = cell o00):
  - wall = FF81818181818 1FF without the space, i.e. FF818181818181FF
  - way = 007E7E7E7E7E7E00
  - man = o32
  - box = 0000000008000000 (o33)
  - destination = 0000000010000000 (o34)
- Levels 1..3: package constants, with these constraints:
  - box count equals destination count;
  - man, boxes and destinations lie on way cells;
  - wall and way are disjoint.
- Edge detection (registered previous values of right, retract, retry, left and cursor):
  - Right, retract and retry events are rising edges of their inputs.
  - A left event occurs when left=1 and either (left was 0 last cycle) or (cursor != previous cursor). Holding left and dragging therefore performs one move per cell change.
- Event priority, one action per cycle:
  1. retry: reload the current stage's man and box; undo_valid=0.
  2. right with game_area=0: stage = stage+1, wrapping 3->0; load that level; undo_valid=0. Right with game_area=1 is ignored.
  3. retract with undo_valid=1: man and box restore to the saved values; undo_valid=0. Retract with undo_valid=0 is ignored.
  4. left with game_area=1 and win=0: move attempt (below).
- Move attempt:
  - Let T = cursor. The direction d is one of -8, +8, -1, +1.
  - T must be 4-adjacent to man. The ±1 directions require the same row, no wrap across row boundaries.
  - Any other T is ignored.
  - If T is way and has no box: save (man, box) to undo; man=T; undo_valid=1.
  - If T has a box: let B = T+d. B must be on-board (and same row for ±1), be way, and have no box. Then save to undo; box clears bit T and sets bit B; man=T; undo_valid=1. Otherwise no change.
  - Wall or non-way T: no change.
- Latency: an event sampled at edge k is visible on the outputs after edge k. win updates combinationally from box.
- While win=1, moves are ignored; retry, right and retract still act.
- Reset asserted mid-operation overrides everything immediately.

Decomposition:
- Package game_core_pkg holds:
  - cell index width (6) and stage width (2);
  - per-level ROM constants: wall, way, destination, initial box, initial man.
- One natural sub-module: game_level_rom (stage in; wall/way/destination/init_box/init_man out, combinational).
- Move legality and edge detection stay in game_core.

Test Plan:
- Reset: reset=1 then 0 -> stage=0, man=o32, box=0000000008000000, wall=FF818181818181FF, win=0.
- Right-click outside board: game_area=0, right 0->1 -> stage=1 and level-1 ROM loaded. Four such clicks -> stage=0, man=o32. Right with game_area=1 -> no change.
- Simple move: from reset, game_area=1, cursor=o31, left rising -> man=o31. Then cursor=o21 while left is held -> man=o21. Cursor=o20 (wall) -> man stays o21. Cursor=o40 (non-adjacent) -> no change.
- Push and win: from reset, cursor=o33, left rising -> man=o33, box=0000000010000000, win=1. Then cursor=o32 with left held -> ignored while win=1.
- Undo: after the push, retract rising -> man=o32, box=0000000008000000, win=0. A second retract -> no change.
- Retry: after moves man=o21, retry rising -> man=o32, box restored. Retry held for 3 cycles -> only one reload; undo_valid=0, so a following retract does nothing.

Source files
------------

// File: rtl/game_core_pkg.sv
// Shared types and level ROM contents for the Sokoban game-state engine.
// Pure constants: no latency, no flow control.
// Levels are indexed by stage; bit i of every board word is cell i (row*8+col).
package game_core_pkg;

    localparam int CELL_W   = 6;
    localparam int STAGE_W  = 2;
    localparam int N_LEVELS = 4;

    typedef logic [CELL_W-1:0]  cell_t;
    typedef logic [STAGE_W-1:0] stage_t;
    typedef logic [63:0]        board_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DN,
        DIR_LF,
        DIR_RT
    } dir_t;

    localparam board_t BORDER_WALL = 64'hFF81_8181_8181_81FF;
    localparam board_t INNER_WAY   = 64'h007E_7E7E_7E7E_7E00;
    localparam board_t PILLAR      = 64'd1 << 6'o44;

    localparam board_t LVL_WALL [N_LEVELS] = '{
        BORDER_WALL, BORDER_WALL, BORDER_WALL, BORDER_WALL | PILLAR
    };
    localparam board_t LVL_WAY [N_LEVELS] = '{
        INNER_WAY, INNER_WAY, INNER_WAY, INNER_WAY & ~PILLAR
    };
    localparam board_t LVL_DEST [N_LEVELS] = '{
        64'h0000_0000_1000_0000,
        64'd1 << 6'o55,
        (64'd1 << 6'o16) | (64'd1 << 6'o61),
        (64'd1 << 6'o52) | (64'd1 << 6'o55)
    };
    localparam board_t LVL_BOX [N_LEVELS] = '{
        64'h0000_0000_0800_0000,
        64'd1 << 6'o22,
        (64'd1 << 6'o23) | (64'd1 << 6'o44),
        (64'd1 << 6'o22) | (64'd1 << 6'o25)
    };
    localparam cell_t LVL_MAN [N_LEVELS] = '{6'o32, 6'o11, 6'o66, 6'o11};

    function automatic board_t cell_bit(input cell_t c);
        return board_t'(1) << c;
    endfunction

endpackage

// File: rtl/game_level_rom.sv
// Level ROM: board bitmaps and starting position for one stage.
// Combinational, zero latency.
// No flow control; outputs follow stage continuously.
module game_level_rom
    import game_core_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    output logic [63:0]        wall,
    output logic [63:0]        way,
    output logic [63:0]        destination,
    output logic [63:0]        init_box,
    output logic [CELL_W-1:0]  init_man
);

    assign wall        = LVL_WALL[stage];
    assign way         = LVL_WAY[stage];
    assign destination = LVL_DEST[stage];
    assign init_box    = LVL_BOX[stage];
    assign init_man    = LVL_MAN[stage];

endmodule

// File: rtl/game_core.sv
// Sokoban state engine: moves, pushes, one-step undo, retry and stage advance.
// Events sampled at a clock edge are visible right after it; win is combinational.
// No backpressure: at most one action is taken per cycle, lower-priority events are dropped.
module game_core
    import game_core_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  cursor,
    input  logic        game_area,
    input  logic        left,
    input  logic        right,
    input  logic        retract,
    input  logic        retry,
    output logic [63:0] wall,
    output logic [63:0] way,
    output logic [63:0] box,
    output logic [63:0] destination,
    output logic [5:0]  man,
    output logic [1:0]  stage,
    output logic        win
);

    board_t cur_box, box_n, undo_box, undo_box_n;
    cell_t  cur_man, man_n, undo_man, undo_man_n;
    stage_t stage_n, stage_wrap;
    logic   undo_valid, undo_valid_n;

    logic   left_q, right_q, retract_q, retry_q;
    cell_t  cursor_q;
    logic   left_ev, right_ev, retract_ev, retry_ev;

    logic [2:0] mr, mc, tr, tc;
    dir_t       dir;
    logic       adj, b_ok, b_free, can_step, can_push;
    cell_t      bcell;

    game_level_rom u_rom (
        .stage       (stage),
        .wall        (wall),
        .way         (way),
        .destination (destination),
        .init_box    (cur_box),
        .init_man    (cur_man)
    );

    assign win        = (box == destination);
    assign stage_wrap = (stage == STAGE_W'(NUM_STAGES - 1)) ? '0 : stage + 1'b1;

    // A held button re-fires on every cursor cell change, so dragging walks the man.
    assign left_ev    = left && (!left_q || (cursor != cursor_q));
    assign right_ev   = right && !right_q;
    assign retract_ev = retract && !retract_q;
    assign retry_ev   = retry && !retry_q;

    assign mr = man[5:3];
    assign mc = man[2:0];
    assign tr = cursor[5:3];
    assign tc = cursor[2:0];

    // Widened compares keep col 7 -> col 0 from looking adjacent.
    always_comb begin
        adj = 1'b1;
        dir = DIR_UP;
        if (tc == mc && ({1'b0, tr} + 4'd1) == {1'b0, mr})
            dir = DIR_UP;
        else if (tc == mc && {1'b0, tr} == ({1'b0, mr} + 4'd1))
            dir = DIR_DN;
        else if (tr == mr && ({1'b0, tc} + 4'd1) == {1'b0, mc})
            dir = DIR_LF;
        else if (tr == mr && {1'b0, tc} == ({1'b0, mc} + 4'd1))
            dir = DIR_RT;
        else
            adj = 1'b0;
    end

    always_comb begin
        b_ok  = 1'b0;
        bcell = cursor;
        unique case (dir)
            DIR_UP: begin b_ok = (tr != 3'd0); bcell = cursor - 6'd8; end
            DIR_DN: begin b_ok = (tr != 3'd7); bcell = cursor + 6'd8; end
            DIR_LF: begin b_ok = (tc != 3'd0); bcell = cursor - 6'd1; end
            DIR_RT: begin b_ok = (tc != 3'd7); bcell = cursor + 6'd1; end
        endcase
    end

    assign b_free   = b_ok && way[bcell] && !box[bcell];
    assign can_step = adj && way[cursor] && !box[cursor];
    assign can_push = adj && box[cursor] && b_free;

    always_comb begin
        stage_n      = stage;
        man_n        = man;
        box_n        = box;
        undo_man_n   = undo_man;
        undo_box_n   = undo_box;
        undo_valid_n = undo_valid;
        if (retry_ev) begin
            man_n        = cur_man;
            box_n        = cur_box;
            undo_valid_n = 1'b0;
        end else if (right_ev && !game_area) begin
            stage_n      = stage_wrap;
            man_n        = LVL_MAN[stage_wrap];
            box_n        = LVL_BOX[stage_wrap];
            undo_valid_n = 1'b0;
        end else if (retract_ev && undo_valid) begin
            man_n        = undo_man;
            box_n        = undo_box;
            undo_valid_n = 1'b0;
        end else if (left_ev && game_area && !win && (can_step || can_push)) begin
            undo_man_n   = man;
            undo_box_n   = box;
            undo_valid_n = 1'b1;
            man_n        = cursor;
            if (can_push)
                box_n = (box & ~cell_bit(cursor)) | cell_bit(bcell);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage      <= '0;
            man        <= LVL_MAN[0];
            box        <= LVL_BOX[0];
            undo_man   <= '0;
            undo_box   <= '0;
            undo_valid <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            retract_q  <= 1'b0;
            retry_q    <= 1'b0;
            cursor_q   <= '0;
        end else begin
            stage      <= stage_n;
            man        <= man_n;
            box        <= box_n;
            undo_man   <= undo_man_n;
            undo_box   <= undo_box_n;
            undo_valid <= undo_valid_n;
            left_q     <= left;
            right_q    <= right;
            retract_q  <= retract;
            retry_q    <= retry;
            cursor_q   <= cursor;
        end
    end

endmodule

// File: tb/tb_game_core.sv
// Directed bench for game_core: expected state is queued per step and checked after the edge.
module tb_game_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  cursor;
    logic        game_area, left, right, retract, retry;
    logic [63:0] wall, way, box, destination;
    logic [5:0]  man;
    logic [1:0]  stage;
    logic        win;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    typedef struct packed {
        logic [2:0]  fld;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    localparam logic [2:0] F_MAN = 3'd0, F_BOX = 3'd1, F_STAGE = 3'd2, F_WIN = 3'd3,
                           F_WALL = 3'd4, F_WAY = 3'd5, F_DEST = 3'd6;

    game_core dut (
        .clk         (clk),
        .reset       (reset),
        .cursor      (cursor),
        .game_area   (game_area),
        .left        (left),
        .right       (right),
        .retract     (retract),
        .retry       (retry),
        .wall        (wall),
        .way         (way),
        .box         (box),
        .destination (destination),
        .man         (man),
        .stage       (stage),
        .win         (win)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] bc(input logic [5:0] c);
        logic [63:0] one;
        one = 64'd1;
        return one << c;
    endfunction

    function automatic string fname(input logic [2:0] f);
        case (f)
            F_MAN:   return "man";
            F_BOX:   return "box";
            F_STAGE: return "stage";
            F_WIN:   return "win";
            F_WALL:  return "wall";
            F_WAY:   return "way";
            default: return "destination";
        endcase
    endfunction

    task automatic push(input logic [2:0] f, input logic [63:0] v);
        sb.push_back('{fld: f, val: v});
    endtask

    task automatic expect_st(input logic [5:0] m, input logic [63:0] b,
                             input logic [1:0] s, input logic w);
        push(F_MAN, 64'(m));
        push(F_BOX, b);
        push(F_STAGE, 64'(s));
        push(F_WIN, 64'(w));
    endtask

    task automatic check_now();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.fld)
                F_MAN:   obs = 64'(man);
                F_BOX:   obs = box;
                F_STAGE: obs = 64'(stage);
                F_WIN:   obs = 64'(win);
                F_WALL:  obs = wall;
                F_WAY:   obs = way;
                default: obs = destination;
            endcase
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL step%0d.%s observed=%h expected=%h", step, fname(e.fld), obs, e.val);
            end
        end
        step++;
    endtask

    task automatic tick_check();
        @(posedge clk);
        #1;
        check_now();
    endtask

    localparam logic [63:0] B0 = 64'h0000_0000_0800_0000;

    initial begin
        reset = 1'b1; cursor = 6'o00; game_area = 1'b0;
        left = 1'b0; right = 1'b0; retract = 1'b0; retry = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state and level 0 ROM
        expect_st(6'o32, B0, 2'd0, 1'b0);
        push(F_WALL, 64'hFF81_8181_8181_81FF);
        push(F_WAY,  64'h007E_7E7E_7E7E_7E00);
        push(F_DEST, 64'h0000_0000_1000_0000);
        tick_check();

        // stage advance outside the board, wrapping after four clicks
        right = 1'b1; expect_st(6'o11, bc(6'o22), 2'd1, 1'b0); tick_check();
        right = 1'b0; expect_st(6'o11, bc(6'o22), 2'd1, 1'b0); tick_check();
        right = 1'b1; expect_st(6'o66, bc(6'o23) | bc(6'o44), 2'd2, 1'b0); tick_check();
        right = 1'b0; tick_check();
        right = 1'b1; expect_st(6'o11, bc(6'o22) | bc(6'o25), 2'd3, 1'b0);
        push(F_WALL, 64'hFF81_8181_8181_81FF | bc(6'o44));
        tick_check();
        right = 1'b0; tick_check();
        right = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        right = 1'b0; tick_check();

        // right click inside the board is ignored
        game_area = 1'b1;
        right = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        right = 1'b0; tick_check();

        // walking, dragging, wall and non-adjacent targets
        cursor = 6'o31; left = 1'b1; expect_st(6'o31, B0, 2'd0, 1'b0); tick_check();
        cursor = 6'o21; expect_st(6'o21, B0, 2'd0, 1'b0); tick_check();
        cursor = 6'o20; expect_st(6'o21, B0, 2'd0, 1'b0); tick_check();
        cursor = 6'o40; expect_st(6'o21, B0, 2'd0, 1'b0); tick_check();
        left = 1'b0; tick_check();

        // retry reloads once; undo is cleared; a held retry does not re-fire
        retry = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        retract = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        retract = 1'b0; cursor = 6'o31; left = 1'b1;
        expect_st(6'o31, B0, 2'd0, 1'b0); tick_check();
        expect_st(6'o31, B0, 2'd0, 1'b0); tick_check();
        retry = 1'b0; left = 1'b0; expect_st(6'o31, B0, 2'd0, 1'b0); tick_check();
        retry = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        retry = 1'b0; tick_check();

        // push onto the target wins; further moves are ignored
        cursor = 6'o33; left = 1'b1; expect_st(6'o33, bc(6'o34), 2'd0, 1'b1); tick_check();
        cursor = 6'o32; expect_st(6'o33, bc(6'o34), 2'd0, 1'b1); tick_check();
        left = 1'b0; tick_check();

        // undo restores once only
        retract = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        retract = 1'b0; tick_check();
        retract = 1'b1; expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();
        retract = 1'b0; tick_check();

        // walk around and push the box up until it hits the top wall
        cursor = 6'o42; left = 1'b1; expect_st(6'o42, B0, 2'd0, 1'b0); tick_check();
        cursor = 6'o43; expect_st(6'o43, B0, 2'd0, 1'b0); tick_check();
        cursor = 6'o33; expect_st(6'o33, bc(6'o23), 2'd0, 1'b0); tick_check();
        cursor = 6'o23; expect_st(6'o23, bc(6'o13), 2'd0, 1'b0); tick_check();
        cursor = 6'o13; expect_st(6'o23, bc(6'o13), 2'd0, 1'b0); tick_check();
        left = 1'b0; tick_check();

        // asynchronous reset acts without waiting for a clock edge
        reset = 1'b1;
        #2;
        expect_st(6'o32, B0, 2'd0, 1'b0);
        check_now();
        reset = 1'b0;
        expect_st(6'o32, B0, 2'd0, 1'b0); tick_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
